// File: rtl/adc128s022_pkg.sv
// Shared constants and types for the ADC128S022-compatible SPI responder.
package adc128s022_pkg;

    localparam int unsigned FrameClocks   = 16;
    localparam int unsigned LeadZeros     = 4;
    localparam int unsigned AddrFirstRise = 3;
    localparam int unsigned AddrBits      = 3;
    localparam int unsigned DataWidth     = 12;

    typedef logic [2:0]  ch_addr_t;
    typedef logic [11:0] sample_t;
    typedef logic [4:0]  edge_cnt_t;

    typedef enum logic {IDLE, ACTIVE} state_e;

    localparam edge_cnt_t LastEdge      = edge_cnt_t'(FrameClocks);
    localparam edge_cnt_t LastZeroFall  = edge_cnt_t'(LeadZeros);
    localparam edge_cnt_t HoldFall      = edge_cnt_t'(LeadZeros + 1);
    localparam edge_cnt_t AddrRiseLo    = edge_cnt_t'(AddrFirstRise);
    localparam edge_cnt_t AddrRiseHi    = edge_cnt_t'(AddrFirstRise + AddrBits - 1);

    // Edge counters run 1..FrameClocks and wrap so frames can run back to back.
    function automatic edge_cnt_t next_cnt(input edge_cnt_t c);
        return (c == LastEdge) ? edge_cnt_t'(1) : c + edge_cnt_t'(1);
    endfunction

endpackage

// File: rtl/adc128s022_responder_sync_edge_det.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses taken from the
// last stage against a one-cycle-delayed copy.
module sync_edge_det #(
    parameter int unsigned Stages  = 2,
    parameter logic        IdleVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {Stages{IdleVal}};
            prev_q <= IdleVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign rise = sync_q[Stages-1] & ~prev_q;
    assign fall = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022-compatible SPI responder: serves channel samples to an ADC master,
// with all link pins oversampled on clk.
module adc128s022_responder #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned NumCh      = 8,
    parameter int unsigned DataWidth  = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adc_cs_n,
    input  logic                       adc_sclk,
    input  logic                       adc_din,
    output logic                       adc_dout,
    input  logic [NumCh*DataWidth-1:0] ch_data,
    output logic [2:0]                 cur_ch,
    output logic                       frame_done,
    output logic                       frame_err
);
    import adc128s022_pkg::*;

    logic                  cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SyncStages-1:0] din_sync;
    logic                  din_s;

    state_e                state_q, state_d;
    edge_cnt_t             rise_cnt_q, rise_cnt_d, fall_cnt_q, fall_cnt_d;
    logic [DataWidth-1:0]  shreg_q, shreg_d, sample;
    ch_addr_t              addr_next_q, addr_next_d, cur_ch_d;
    logic                  dout_d, done_d, err_d;

    sync_edge_det #(.Stages(SyncStages), .IdleVal(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (adc_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_det #(.Stages(SyncStages), .IdleVal(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (adc_sclk),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_sync <= '0;
        else        din_sync <= {din_sync[SyncStages-2:0], adc_din};
    end
    assign din_s = din_sync[SyncStages-1];

    assign sample = ch_data[32'(cur_ch) * DataWidth +: DataWidth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cs_n edges take priority over any sclk edge seen in the same cycle.
    always_comb begin
        rise_cnt_d  = rise_cnt_q;
        fall_cnt_d  = fall_cnt_q;
        shreg_d     = shreg_q;
        addr_next_d = addr_next_q;
        cur_ch_d    = cur_ch;
        dout_d      = adc_dout;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                rise_cnt_d = '0;
                fall_cnt_d = '0;
                dout_d     = 1'b0;
            end
        end else if (cs_rise) begin
            dout_d = 1'b0;
            err_d  = (rise_cnt_q != '0) && (rise_cnt_q != LastEdge);
        end else begin
            if (sck_fall) begin
                fall_cnt_d = next_cnt(fall_cnt_q);
                if (fall_cnt_d <= LastZeroFall) begin
                    dout_d = 1'b0;
                end else if (fall_cnt_d == HoldFall) begin
                    shreg_d = sample;
                    dout_d  = sample[DataWidth-1];
                end else begin
                    dout_d  = shreg_q[DataWidth-2];
                    shreg_d = {shreg_q[DataWidth-2:0], 1'b0};
                end
            end
            if (sck_rise) begin
                rise_cnt_d = next_cnt(rise_cnt_q);
                if (rise_cnt_d >= AddrRiseLo && rise_cnt_d <= AddrRiseHi)
                    addr_next_d = {addr_next_q[AddrBits-2:0], din_s};
                if (rise_cnt_d == LastEdge) begin
                    cur_ch_d = addr_next_q;
                    done_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            shreg_q     <= '0;
            addr_next_q <= '0;
            cur_ch      <= '0;
            adc_dout    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            shreg_q     <= shreg_d;
            addr_next_q <= addr_next_d;
            cur_ch      <= cur_ch_d;
            adc_dout    <= dout_d;
            frame_done  <= done_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Self-checking bench: an SPI master model drives frames and a channel-pointer
// model predicts the returned samples, pulses and cur_ch.
module tb_adc128s022_responder;

    localparam int unsigned NumCh = 8;
    localparam int unsigned DW    = 12;

    logic                clk = 1'b0;
    logic                rst_n, adc_cs_n, adc_sclk, adc_din;
    logic                adc_dout, frame_done, frame_err;
    logic [NumCh*DW-1:0] ch_data;
    logic [2:0]          cur_ch;

    int errors = 0, checks = 0;
    int done_seen = 0, err_seen = 0;
    int model_cur = 0;

    always #5 clk = ~clk;

    adc128s022_responder #(.SyncStages(2), .NumCh(NumCh), .DataWidth(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .adc_din   (adc_din),
        .adc_dout  (adc_dout),
        .ch_data   (ch_data),
        .cur_ch    (cur_ch),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (frame_done) done_seen++;
        if (frame_err)  err_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // stop_rise = 16 runs a full frame; smaller values end the frame after that
    // many rises, either by raising cs_n or by pulsing rst_n.
    task automatic do_frame(input logic [2:0] addr, input int unsigned stop_rise,
                            input bit by_reset, input bit keep_cs, input int unsigned half,
                            input int unsigned chg_fall, input logic [NumCh*DW-1:0] chg_data,
                            output logic [15:0] rx);
        logic [11:0] exp_sample;
        logic [2:0]  addr_sh;
        int          done0, err0;
        exp_sample = ch_data[model_cur*DW +: DW];
        done0      = done_seen;
        err0       = err_seen;
        addr_sh    = addr;
        rx         = '0;
        if (adc_cs_n) begin
            adc_cs_n = 1'b0;
            repeat (half) @(negedge clk);
        end
        for (int i = 1; i <= int'(stop_rise); i++) begin
            adc_sclk = 1'b0;
            if (i >= 3 && i <= 5) begin
                adc_din = addr_sh[2];
                addr_sh = addr_sh << 1;
            end else begin
                adc_din = 1'($urandom_range(0, 1));
            end
            repeat (half) @(negedge clk);
            if (i == int'(chg_fall)) ch_data = chg_data;
            rx = {rx[14:0], adc_dout};
            adc_sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
        if (stop_rise < 16 && by_reset) begin
            rst_n = 1'b0;
            #1;
            check("rst_dout", 32'(adc_dout), 32'(0));
            check("rst_cur", 32'(cur_ch), 32'(0));
            adc_cs_n = 1'b1;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            model_cur = 0;
            repeat (half + 4) @(negedge clk);
            check("rst_no_done", 32'(done_seen - done0), 32'(0));
            check("rst_no_err", 32'(err_seen - err0), 32'(0));
        end else if (stop_rise < 16) begin
            adc_cs_n = 1'b1;
            repeat (half + 4) @(negedge clk);
            check("abort_err", 32'(err_seen - err0), (stop_rise >= 1) ? 32'(1) : 32'(0));
            check("abort_done", 32'(done_seen - done0), 32'(0));
            check("abort_cur", 32'(cur_ch), 32'(model_cur));
            check("abort_dout", 32'(adc_dout), 32'(0));
        end else begin
            if (!keep_cs) begin
                adc_cs_n = 1'b1;
                repeat (half + 4) @(negedge clk);
            end
            check("frame_rx", 32'(rx), 32'({4'b0000, exp_sample}));
            check("frame_done", 32'(done_seen - done0), 32'(1));
            check("frame_err", 32'(err_seen - err0), 32'(0));
            model_cur = int'(addr);
            check("frame_cur", 32'(cur_ch), 32'(model_cur));
            if (!keep_cs) check("idle_dout", 32'(adc_dout), 32'(0));
        end
    endtask

    typedef struct {
        logic [NumCh*DW-1:0] data;
        logic [2:0]          addr;
        bit                  keep_cs;
        logic [11:0]         exp_read;
        logic [2:0]          exp_cur;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [15:0] rx;
        int          d0, e0;

        vecs[0] = '{{12'h0, 12'h0, 12'h123, 12'h0, 12'h0, 12'h0, 12'h0, 12'hA5C}, 3'd5, 1'b0, 12'hA5C, 3'd5};
        vecs[1] = '{{12'h0, 12'h0, 12'h123, 12'h0, 12'h0, 12'h0, 12'h0, 12'hA5C}, 3'd0, 1'b0, 12'h123, 3'd0};
        vecs[2] = '{{12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}, 3'd3, 1'b1, 12'h100, 3'd3};
        vecs[3] = '{{12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}, 3'd7, 1'b1, 12'h103, 3'd7};
        vecs[4] = '{{12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}, 3'd1, 1'b0, 12'h107, 3'd1};

        rst_n = 1'b0; adc_cs_n = 1'b1; adc_sclk = 1'b1; adc_din = 1'b0; ch_data = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", 32'(adc_dout), 32'(0));
        check("reset_cur", 32'(cur_ch), 32'(0));
        check("reset_pulses", 32'({frame_done, frame_err}), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // sclk activity with cs_n high must be ignored
        for (int i = 0; i < 20; i++) begin
            adc_sclk = ~adc_sclk;
            adc_din  = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
        end
        adc_sclk = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_cur", 32'(cur_ch), 32'(0));
        check("idle_dout0", 32'(adc_dout), 32'(0));
        check("idle_no_pulse", 32'(done_seen + err_seen), 32'(0));

        // table: addressed reads and back-to-back frames
        for (int v = 0; v < 5; v++) begin
            ch_data = vecs[v].data;
            do_frame(vecs[v].addr, 16, 1'b0, vecs[v].keep_cs, 4, 0, ch_data, rx);
            check("tbl_read", 32'(rx), 32'({4'b0000, vecs[v].exp_read}));
            check("tbl_cur", 32'(cur_ch), 32'(vecs[v].exp_cur));
        end

        // aborted frame leaves cur_ch alone
        do_frame(3'd2, 16, 1'b0, 1'b0, 4, 0, ch_data, rx);
        ch_data = {12'h307, 12'h306, 12'h305, 12'h304, 12'h303, 12'h302, 12'h301, 12'h300};
        e0 = err_seen;
        do_frame(3'd6, 6, 1'b0, 1'b0, 4, 0, ch_data, rx);
        check("abort_one_pulse", 32'(err_seen - e0), 32'(1));
        check("abort_keep_cur", 32'(cur_ch), 32'(2));
        do_frame(3'd1, 16, 1'b0, 1'b0, 4, 0, ch_data, rx);
        check("after_abort_read", 32'(rx[11:0]), 32'(12'h302));

        // sample is held from fall 5 even if the input changes later
        ch_data = '1;
        do_frame(3'd4, 16, 1'b0, 1'b0, 5, 8, '0, rx);
        check("track_hold", 32'(rx[11:0]), 32'(12'hFFF));

        // reset in the middle of a frame
        ch_data = {12'h7C7, 12'h6C6, 12'h5C5, 12'h4C4, 12'h3C3, 12'h2C2, 12'h1C1, 12'h0C0};
        d0 = done_seen;
        do_frame(3'd4, 9, 1'b1, 1'b0, 4, 0, ch_data, rx);
        check("post_rst_cur", 32'(cur_ch), 32'(0));
        check("post_rst_no_done", 32'(done_seen - d0), 32'(0));
        do_frame(3'd3, 16, 1'b0, 1'b0, 4, 0, ch_data, rx);
        check("post_rst_read", 32'(rx[11:0]), 32'(12'h0C0));

        // randomized frames against the channel-pointer model
        for (int n = 0; n < 40; n++) begin
            int unsigned stop, half;
            bit          keep, rst_kind;
            half     = $urandom_range(4, 7);
            ch_data  = {$urandom, $urandom, $urandom};
            stop     = ($urandom_range(0, 9) < 8) ? 16 : $urandom_range(0, 15);
            rst_kind = (stop >= 1 && stop < 16) ? ($urandom_range(0, 4) == 0) : 1'b0;
            keep     = (stop == 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_frame(3'($urandom_range(0, 7)), stop, rst_kind, keep, half, 0, ch_data, rx);
        end
        if (!adc_cs_n) begin
            adc_cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc128s022_responder.md
Name: adc128s022_responder

Overview:
- Synthesizable ADC128S022-compatible SPI responder: the converter side of the 4-wire serial link (cs_n/sclk/din in, dout out) used by the team's ADC master.
- Serves 12-bit samples from eight parallel channel inputs, so the ADC master can be tested in loopback on-chip and in simulation without the real chip.
- All link inputs are oversampled on the system clock; there is no logic in the sclk domain.

Parameters:
SyncStages, 2, synchronizer depth on adc_cs_n, adc_sclk and adc_din (minimum 2)
NumCh, 8, number of channels (fixed by the 3-bit address)
DataWidth, 12, sample width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
adc_cs_n  input  1  chip select, active low, asynchronous to clk
adc_sclk  input  1  serial clock, idles high, asynchronous to clk
adc_din  input  1  control bits from master
adc_dout  output  1  serial data to master
ch_data  input  NumCh*DataWidth  channel samples, ch k at [k*12 +: 12]
cur_ch  output  3  channel that the next frame converts
frame_done  output  1  1-clk pulse on completion of a 16-clock frame
frame_err  output  1  1-clk pulse when cs_n rises mid-frame

Behaviour:
- Reset values: adc_dout=0, cur_ch=0, frame_done=0, frame_err=0, all counters and shift registers 0, synchronizers to idle (cs_n=1, sclk=1).
- Input conditioning: every pin passes through SyncStages flops; edges are detected from the last stage against a one-cycle-delayed copy.
- Timing requirement: sclk high and low phases are each >= SyncStages+2 clk cycles.
- Output latency: adc_dout is registered and updates SyncStages clk edges after the first clk edge that samples the new sclk level.
- FSM state IDLE (cs_n high): sclk edges ignored; adc_dout=0.
- FSM state ACTIVE:
  - Entered on synchronized cs_n fall; edge counters cleared; adc_dout=0.
  - An sclk edge detected in the same cycle as the cs_n fall is ignored.
- Edge counters: rise_cnt and fall_cnt run 1..16 and wrap within ACTIVE.
- Falls 1-4 drive adc_dout=0 (leading zeros).
- Fall 5 (track/hold):
  - Latches ch_data[cur_ch] into the 12-bit shift register and drives bit 11.
  - Later ch_data changes do not affect the frame in progress.
- Falls 6-16 drive bits 10..0, MSB first.
- Rises 3, 4, 5 sample adc_din into addr_next[2], [1], [0]. All other din bits are don't-care.
- Rise 16 (frame complete):
  - cur_ch <= addr_next and frame_done pulses.
  - Counters wrap, so back-to-back frames with cs_n held low are supported: the next fall is fall 1 of the next frame.
- Address pipelining is as in the real chip: the address sent in frame N selects the sample returned in frame N+1. The first frame after reset returns ch 0.
- cs_n rise with rise_cnt not in {0,16}:
  - frame_err pulses; cur_ch is unchanged (aborted frame is not committed).
  - Return to IDLE; adc_dout=0.
- cs_n rise with rise_cnt in {0,16}: return to IDLE, no error.
- cs_n rise and sclk edge in the same cycle: cs_n wins; the edge is ignored.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded and cur_ch=0.

Decomposition:
- Package adc128s022_pkg:
  - FrameClocks=16, LeadZeros=4, AddrFirstRise=3, AddrBits=3, DataWidth=12.
  - Typedefs ch_addr_t (logic [2:0]), sample_t (logic [11:0]), enum state_e {IDLE, ACTIVE}.
- One sub-module, sync_edge_det: parameterized synchronizer with rise/fall pulse outputs, instantiated for cs_n and sclk. din uses its sync output only.

Test Plan:
1. Reset with pins idle -> adc_dout=0, cur_ch=0, no pulses; 20 sclk toggles with cs_n high -> no state change.
2. ch0=12'hA5C, ch5=12'h123; frame 1 sends addr 5, frame 2 sends addr 0, ADC master clk divide 4 -> frame 1 reads 12'hA5C, frame 2 reads 12'h123; cur_ch=5 after frame 1, 0 after frame 2; one frame_done per frame.
3. cs_n held low over 3 back-to-back frames sending addr 3, 7, 1, with chN=12'h100+N -> reads 12'h100, 12'h103, 12'h107; first 4 dout bits of each frame are 0.
4. Frame aborted by cs_n rise after 6 rises with addr 6, previous cur_ch=2 -> frame_err for 1 clk; cur_ch stays 2; next full frame returns ch2.
5. ch_data[cur_ch] changes from 12'hFFF to 12'h000 between fall 5 and fall 16 -> master reads 12'hFFF.
6. rst_n pulsed after rise 9 of a frame with addr 4 -> outputs at reset values; next frame returns ch0; cur_ch=0 until that frame completes.
